// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - FSM states, saturating add and Q-shift multiply helpers, Izhikevich model constants
package izh_pkg;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   // Wide enough to hold any full product of two N<=24-bit operands before rescaling.
   typedef logic signed [63:0] wide_t;

   function automatic wide_t sat(input wide_t x, input int n);
      wide_t hi, lo;
      hi  = (64'sd1 <<< (n - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (n - 1));
      sat = x;
      if (x > hi) sat = hi;
      if (x < lo) sat = lo;
   endfunction

   function automatic wide_t mulq(input wide_t a, input wide_t b, input int q);
      mulq = (a * b) >>> q;
   endfunction

   function automatic wide_t k_004(input int q);
      k_004 = ((64'sd4 <<< q) + 64'sd50) / 64'sd100;
   endfunction

   function automatic wide_t k_5(input int q);
      k_5 = 64'sd5 <<< q;
   endfunction

   function automatic wide_t k_140(input int q);
      k_140 = 64'sd140 <<< q;
   endfunction

endpackage

// File: rtl/izhikevich_update.sv
// rtl/izhikevich_update.sv - combinational single-neuron Izhikevich update datapath
// Products stay full width; each running sum is clamped to N bits, evaluated left to right.
module izhikevich_update
   import izh_pkg::*;
#(
   parameter int N = 18,
   parameter int Q = 10
) (
   input  logic signed [N-1:0] v,
   input  logic signed [N-1:0] w,
   input  logic signed [N-1:0] cur,
   input  logic signed [N-1:0] v_th,
   input  logic signed [N-1:0] c,
   input  logic signed [N-1:0] d,
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   input  logic signed [N-1:0] dv_step,
   input  logic signed [N-1:0] dw_step,
   output logic signed [N-1:0] v_new,
   output logic signed [N-1:0] w_new,
   output logic signed [N-1:0] w_int,
   output logic                spike
);

   localparam wide_t K_004 = k_004(Q);
   localparam wide_t K_5   = k_5(Q);
   localparam wide_t K_140 = k_140(Q);

   wide_t vx, wx, s1, s2, s3, s4, dv, bvw, dw;

   always_comb begin
      vx    = wide_t'(v);
      wx    = wide_t'(w);
      s1    = sat(mulq(K_004, mulq(vx, vx, Q), Q) + mulq(K_5, vx, Q), N);
      s2    = sat(s1 + K_140, N);
      s3    = sat(s2 - wx, N);
      s4    = sat(s3 + wide_t'(cur), N);
      dv    = mulq(s4, wide_t'(dv_step), Q);
      bvw   = sat(mulq(wide_t'(b), vx, Q) - wx, N);
      dw    = mulq(mulq(wide_t'(a), bvw, Q), wide_t'(dw_step), Q);
      spike = v > v_th;
      // w_int is also the refractory-hold result, so it is exported separately
      w_int = N'(sat(wx + dw, N));
      v_new = spike ? c : N'(sat(vx + dv, N));
      w_new = spike ? N'(sat(wx + wide_t'(d), N)) : w_int;
   end

endmodule

// File: rtl/izhikevich_array.sv
// rtl/izhikevich_array.sv - time-multiplexed Izhikevich neuron array, one neuron update per cycle
// Optional refractory counters: define IZH_REFRACTORY_EN.
module izhikevich_array
   import izh_pkg::*;
#(
   parameter int N       = 18,
   parameter int Q       = 10,
   parameter int NEURONS = 8,
   parameter int REF_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       apply,
   input  logic                       i_we,
   input  logic [$clog2(NEURONS)-1:0] i_addr,
   input  logic signed [N-1:0]        i_data,
   input  logic signed [N-1:0]        v_init,
   input  logic signed [N-1:0]        w_init,
   input  logic signed [N-1:0]        v_th,
   input  logic signed [N-1:0]        c,
   input  logic signed [N-1:0]        d,
   input  logic signed [N-1:0]        a,
   input  logic signed [N-1:0]        b,
   input  logic signed [N-1:0]        dv_step,
   input  logic signed [N-1:0]        dw_step,
   input  logic [REF_W-1:0]           ref_period,
   input  logic [$clog2(NEURONS)-1:0] rd_addr,
   output logic signed [N-1:0]        rd_voltage,
   output logic signed [N-1:0]        rd_w,
   output logic [NEURONS-1:0]         spikes,
   output logic                       busy,
   output logic                       done
);

   localparam int AW = $clog2(NEURONS);

   state_e              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic signed [N-1:0] v_q [NEURONS];
   logic signed [N-1:0] v_d [NEURONS];
   logic signed [N-1:0] w_q [NEURONS];
   logic signed [N-1:0] w_d [NEURONS];
   logic signed [N-1:0] cur_q [NEURONS];
   logic signed [N-1:0] cur_d [NEURONS];
   logic [NEURONS-1:0]  spikes_q, spikes_d;
   logic signed [N-1:0] upd_v, upd_w, upd_w_int;
   logic                upd_spike;
   logic                rd_ok, wr_ok;
`ifdef IZH_REFRACTORY_EN
   logic [REF_W-1:0]    ref_q [NEURONS];
   logic [REF_W-1:0]    ref_d [NEURONS];
`else
   logic                unused_ref;
   assign unused_ref = ^{ref_period, upd_w_int};
`endif

   // Only a non-power-of-two array can see addresses past its last neuron.
   if (NEURONS == (1 << AW)) begin : g_full
      assign rd_ok = 1'b1;
      assign wr_ok = 1'b1;
   end else begin : g_part
      assign rd_ok = 32'(rd_addr) < 32'(NEURONS);
      assign wr_ok = 32'(i_addr) < 32'(NEURONS);
   end

   izhikevich_update #(.N(N), .Q(Q)) u_update (
      .v(v_q[idx_q]), .w(w_q[idx_q]), .cur(cur_q[idx_q]), .v_th(v_th), .c(c), .d(d),
      .a(a), .b(b), .dv_step(dv_step), .dw_step(dw_step),
      .v_new(upd_v), .w_new(upd_w), .w_int(upd_w_int), .spike(upd_spike)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      v_d      = v_q;
      w_d      = w_q;
      cur_d    = cur_q;
      spikes_d = spikes_q;
`ifdef IZH_REFRACTORY_EN
      ref_d    = ref_q;
`endif
      // The datapath reads cur_q, so a same-cycle write lands for the next sweep.
      if (i_we && wr_ok) cur_d[i_addr] = i_data;
      case (state_q)
         S_IDLE: begin
            if (apply) begin
               state_d = S_RUN;
               idx_d   = '0;
            end
         end
         S_RUN: begin
`ifdef IZH_REFRACTORY_EN
            if (ref_q[idx_q] != '0) begin
               v_d[idx_q]      = c;
               w_d[idx_q]      = upd_w_int;
               spikes_d[idx_q] = 1'b0;
               ref_d[idx_q]    = ref_q[idx_q] - 1'b1;
            end else begin
               v_d[idx_q]      = upd_v;
               w_d[idx_q]      = upd_w;
               spikes_d[idx_q] = upd_spike;
               ref_d[idx_q]    = upd_spike ? ref_period : '0;
            end
`else
            v_d[idx_q]      = upd_v;
            w_d[idx_q]      = upd_w;
            spikes_d[idx_q] = upd_spike;
`endif
            if (idx_q == AW'(NEURONS - 1)) state_d = S_DONE;
            else                           idx_d   = idx_q + 1'b1;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         spikes_q <= '0;
         for (int k = 0; k < NEURONS; k++) begin
            v_q[k]   <= v_init;
            w_q[k]   <= w_init;
            cur_q[k] <= '0;
`ifdef IZH_REFRACTORY_EN
            ref_q[k] <= '0;
`endif
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         spikes_q <= spikes_d;
         v_q      <= v_d;
         w_q      <= w_d;
         cur_q    <= cur_d;
`ifdef IZH_REFRACTORY_EN
         ref_q    <= ref_d;
`endif
      end
   end

   assign rd_voltage = rd_ok ? v_q[rd_addr] : '0;
   assign rd_w       = rd_ok ? w_q[rd_addr] : '0;
   assign spikes     = spikes_q;
   assign busy       = state_q == S_RUN;
   assign done       = state_q == S_DONE;

endmodule

// File: doc/izhikevich_array.md
IZHIKEVICH_ARRAY -- requirements
Module: izhikevich_array

Interface
REQ-001 SHALL have parameter N, default 18, total signed fixed-point width.
REQ-002 SHALL have parameter Q, default 10, fractional bits.
REQ-003 SHALL have parameter NEURONS, default 8, number of time-multiplexed neurons (>=2).
REQ-004 SHALL have parameter REF_W, default 4, refractory counter width.
REQ-005 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-006 Ports, in order:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- apply, input, 1, start one sweep over all neurons.
- i_we, input, 1, current write enable.
- i_addr, input, clog2(NEURONS), current write index.
- i_data, input, N, input current.
- v_init, w_init, input, N each, reset state.
- v_th, c, d, a, b, dv_step, dw_step, input, N each, shared model constants.
- ref_period, input, REF_W, refractory sweeps.
- rd_addr, input, clog2(NEURONS), state read index.
- rd_voltage, rd_w, output, N each, state of neuron rd_addr, combinational read.
- spikes, output, NEURONS, spike flag per neuron from last sweep.
- busy, output, 1, sweep in progress.
- done, output, 1, one-cycle sweep-complete pulse.

Function
REQ-007 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-008 IDLE with apply=1 SHALL enter RUN with index 0; apply in RUN or DONE SHALL be ignored.
REQ-009 RUN SHALL update neuron[index] once per cycle, index 0..NEURONS-1; after index NEURONS-1 it SHALL enter DONE.
REQ-010 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; done rises NEURONS+1 cycles after apply is sampled.
REQ-011 dv SHALL equal (0.04v^2 + 5v + 140 - w + i) * dv_step; dw SHALL equal a*(b*v - w) * dw_step.
REQ-012 Every fixed-point product SHALL be the full signed product arithmetically shifted right by Q.
REQ-013 Every add SHALL saturate to the signed N-bit range [-2^(N-1), 2^(N-1)-1].
REQ-014 If signed v > v_th (strict), the update SHALL set v=c, w=sat(w+d), spikes[k]=1; otherwise v=sat(v+dv), w=sat(w+dw), spikes[k]=0.
REQ-015 i_we SHALL be accepted in any state; a write to neuron k in the cycle neuron k is updated SHALL take effect from the next sweep.
REQ-016 Out-of-range i_addr or rd_addr (>= NEURONS) writes SHALL be dropped; reads SHALL return 0.

Reset
REQ-017 rst SHALL force IDLE, all v=v_init, all w=w_init, all currents 0, spikes=0, busy=0, done=0, refractory counters 0.
REQ-018 rst SHALL take priority over apply and i_we, and SHALL abort a sweep in progress without a done pulse.

Configuration
REQ-019 With IZH_REFRACTORY_EN defined, a spike SHALL load ref_period into neuron k's counter; while nonzero, the update SHALL hold v=c, apply w=sat(w+dw), force spikes[k]=0, and decrement the counter.
REQ-020 Without IZH_REFRACTORY_EN, no counters SHALL exist and ref_period SHALL be ignored; the port remains.

Structure
REQ-021 Package izh_pkg SHALL hold the FSM state enum, the saturating add and Q-shift multiply functions, and the model constants 0.04, 5, and 140 in Q format.
REQ-022 Sub-module izhikevich_update SHALL be the combinational single-neuron datapath (v, w, i, constants -> new v, new w, spike), instantiated once.

Verification (N=18, Q=10, NEURONS=8)
REQ-023 Reset: rst with v_init=-66560 (-65.0) and w_init=-13312 -> every rd_addr returns -66560 / -13312; spikes=0; busy=0.
REQ-024 Timing: apply pulsed at cycle 0 -> busy=1 cycles 1-8, done=1 cycle 9 only; a second apply at cycle 4 causes no extra sweep.
REQ-025 Spike: v_init=31744 (31.0), v_th=30720, c=-66560, d=2048 -> after one sweep all v=-66560, w=w_init+2048, spikes=8'hFF.
REQ-026 Saturation: v_th=131071, i_data=130048 written to neuron 0, repeated sweeps -> neuron 0 v reaches 131071 and never wraps negative.
REQ-027 Refractory (IZH_REFRACTORY_EN, ref_period=2): after a spike, the next 2 sweeps give spikes[k]=0 and v=c; the 3rd sweep resumes normal integration.
REQ-028 Abort: rst asserted at cycle 5 of a sweep -> IDLE next cycle, no done pulse, all state equals the reset values.
